control_unit: RTL

Multi-cycle control unit for the 16-bit windowed-register CPU. It receives `opcode` and `func` from the datapath. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives every datapath control input. It also adds a PC write enable, which the datapath needs in order to hold the PC across multi-cycle instructions.

---
 rtl/cpu_pkg.sv | 65 ++++++
 rtl/control_decoder.sv | 62 ++++++
 rtl/control_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit windowed-register CPU control path:
// FSM states, opcode encodings, R-type func bit indices, one-hot ALU ops
// and the decoder result payload.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned FUNC_W   = 8;
    localparam int unsigned ALU_OP_W = 7;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_JUMP   = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 4'b1000;
    localparam logic [OPCODE_W-1:0] OP_ADDI   = 4'b1100;
    localparam logic [OPCODE_W-1:0] OP_SUBI   = 4'b1101;
    localparam logic [OPCODE_W-1:0] OP_ANDI   = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_ORI    = 4'b1111;

    localparam int unsigned FN_MOVE = 0;
    localparam int unsigned FN_ADD  = 1;
    localparam int unsigned FN_SUB  = 2;
    localparam int unsigned FN_AND  = 3;
    localparam int unsigned FN_OR   = 4;
    localparam int unsigned FN_NOT  = 5;
    localparam int unsigned FN_NOP  = 6;
    localparam int unsigned FN_WND  = 7;

    localparam logic [ALU_OP_W-1:0] ALU_NONE = 7'h00;
    localparam logic [ALU_OP_W-1:0] ALU_MOVE = 7'h01;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 7'h02;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 7'h04;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 7'h08;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 7'h10;
    localparam logic [ALU_OP_W-1:0] ALU_NOT  = 7'h20;
    localparam logic [ALU_OP_W-1:0] ALU_EQ   = 7'h40;

    // Instruction class: determines the state sequence and strobes
    typedef enum logic [2:0] {
        CLS_LOAD   = 3'd0,
        CLS_STORE  = 3'd1,
        CLS_JUMP   = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_ALU    = 3'd4,
        CLS_NOP    = 3'd5,
        CLS_WND    = 3'd6
    } iclass_t;

    typedef struct packed {
        iclass_t               cls;
        logic [ALU_OP_W-1:0]   aluop;
        logic                  immd;
        logic                  illegal;
    } dec_t;

endpackage

// File: rtl/control_decoder.sv
// Combinational instruction decoder.
// Ports: i_op (opcode), i_func (R-type func) -> o_dec (class, one-hot ALU op,
// immediate select, illegal flag). Illegal encodings report class NOP.
module control_decoder
    import cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_op,
    input  logic [FUNC_W-1:0]   i_func,
    output dec_t                o_dec
);

    always_comb begin
        o_dec.cls     = CLS_NOP;
        o_dec.aluop   = ALU_NONE;
        o_dec.immd    = 1'b0;
        o_dec.illegal = 1'b0;
        case (i_op)
            OP_LOAD:   o_dec.cls = CLS_LOAD;
            OP_STORE:  o_dec.cls = CLS_STORE;
            OP_JUMP:   o_dec.cls = CLS_JUMP;
            OP_BRANCH: begin
                o_dec.cls   = CLS_BRANCH;
                o_dec.aluop = ALU_EQ;
            end
            OP_RTYPE: begin
                if (!$onehot(i_func)) begin
                    o_dec.illegal = 1'b1;
                end else if (i_func[FN_NOP]) begin
                    o_dec.cls = CLS_NOP;
                end else if (i_func[FN_WND]) begin
                    o_dec.cls = CLS_WND;
                end else begin
                    // func bits 0..5 line up with ALUop bits 0..5
                    o_dec.cls   = CLS_ALU;
                    o_dec.aluop = {1'b0, i_func[FN_NOT:FN_MOVE]};
                end
            end
            OP_ADDI: begin
                o_dec.cls   = CLS_ALU;
                o_dec.aluop = ALU_ADD;
                o_dec.immd  = 1'b1;
            end
            OP_SUBI: begin
                o_dec.cls   = CLS_ALU;
                o_dec.aluop = ALU_SUB;
                o_dec.immd  = 1'b1;
            end
            OP_ANDI: begin
                o_dec.cls   = CLS_ALU;
                o_dec.aluop = ALU_AND;
                o_dec.immd  = 1'b1;
            end
            OP_ORI: begin
                o_dec.cls   = CLS_ALU;
                o_dec.aluop = ALU_OR;
                o_dec.immd  = 1'b1;
            end
            default: o_dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath controls as a Moore decode of state + latched instruction, gated
// by stall.
// Ports: clk, rst (async active-low), opcode, func, stall in;
// pc_en, jump, mem_write, immdSel, memOrALU, toWrite, setWindow, ALUop,
// instr_done, halted out.
// Build option: CTRL_ILLEGAL_TRAP_EN traps illegal encodings into HALT;
// otherwise they run as a 3-cycle NOP and halted is tied low.
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ALUOP_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         opcode,
    input  logic [7:0]         func,
    input  logic               stall,
    output logic               pc_en,
    output logic               jump,
    output logic               mem_write,
    output logic               immdSel,
    output logic               memOrALU,
    output logic               toWrite,
    output logic               setWindow,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               instr_done,
    output logic               halted
);

    state_t              r_state;
    state_t              w_state_next;
    logic [OPCODE_W-1:0] r_ir_op;
    logic [FUNC_W-1:0]   r_ir_func;
    logic [OPCODE_W-1:0] w_dec_op;
    logic [FUNC_W-1:0]   w_dec_func;
    dec_t                w_dec;
    logic                w_exec_last;
    logic                w_final;
    logic                w_steer;

    // DECODE sees the live bus (trap check); later states use the latched copy
    assign w_dec_op   = (r_state == ST_DECODE) ? opcode : r_ir_op;
    assign w_dec_func = (r_state == ST_DECODE) ? func   : r_ir_func;

    control_decoder u_decoder (
        .i_op   (w_dec_op),
        .i_func (w_dec_func),
        .o_dec  (w_dec)
    );

    assign w_exec_last = w_dec.illegal ||
                         (w_dec.cls inside {CLS_JUMP, CLS_BRANCH, CLS_NOP, CLS_WND});
    // WB is only ever the last state; MEM is last only for STORE
    assign w_final = ((r_state == ST_EXEC) && w_exec_last) ||
                     ((r_state == ST_MEM)  && (w_dec.cls == CLS_STORE)) ||
                     (r_state == ST_WB);
    assign w_steer = (r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Instruction latch, captured when leaving DECODE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ir_op   <= '0;
            r_ir_func <= '0;
        end else if ((r_state == ST_DECODE) && !stall) begin
            r_ir_op   <= opcode;
            r_ir_func <= func;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (!stall) begin
            case (r_state)
                ST_FETCH:  w_state_next = ST_DECODE;
`ifdef CTRL_ILLEGAL_TRAP_EN
                ST_DECODE: w_state_next = w_dec.illegal ? ST_HALT : ST_EXEC;
`else
                ST_DECODE: w_state_next = ST_EXEC;
`endif
                ST_EXEC: begin
                    if (w_exec_last)                w_state_next = ST_FETCH;
                    else if (w_dec.cls == CLS_ALU)  w_state_next = ST_WB;
                    else                            w_state_next = ST_MEM;
                end
                ST_MEM:    w_state_next = (w_dec.cls == CLS_LOAD) ? ST_WB : ST_FETCH;
                ST_WB:     w_state_next = ST_FETCH;
                ST_HALT:   w_state_next = ST_HALT;
                default:   w_state_next = ST_FETCH;
            endcase
        end
    end

    // Output decode
    always_comb begin
        pc_en      = 1'b0;
        jump       = 1'b0;
        mem_write  = 1'b0;
        immdSel    = 1'b0;
        memOrALU   = 1'b0;
        toWrite    = 1'b0;
        setWindow  = 1'b0;
        ALUop      = '0;
        instr_done = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        halted     = (r_state == ST_HALT);
`else
        halted     = 1'b0;
`endif
        if (w_steer) begin
            ALUop    = ALUOP_W'(w_dec.aluop);
            immdSel  = w_dec.immd;
            memOrALU = (w_dec.cls != CLS_LOAD);
            jump     = (w_dec.cls == CLS_JUMP);
        end
        if (!stall) begin
            mem_write  = (r_state == ST_MEM) && (w_dec.cls == CLS_STORE);
            toWrite    = (r_state == ST_WB);
            setWindow  = (r_state == ST_EXEC) && (w_dec.cls == CLS_WND);
            pc_en      = w_final;
            instr_done = w_final;
        end
    end

endmodule
